if_fetch: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, sitting directly upstream of the IF/ID pipeline register. Owns the PC, drives a req/ack instruction-memory port and buffers up to two fetched words in a small FIFO. Presents the head word to IF/ID, and requests a pipeline stall while it has nothing to present. Handles branch redirects from ID, preserving the delay slot, and flush redirects from the control unit, discarding in-flight fetches.

---
 rtl/if_fetch_pkg.sv | 28 ++
 rtl/if_fetch_buf.sv | 59 +++++
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, constants, FSM encoding and buffer entry type for the IF stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord  = 32'h0000_0000;
  localparam logic               RstEnable = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no request on the memory port
    BUSY  = 2'd1,  // request outstanding, returned word is kept
    DRAIN = 2'd2   // request outstanding, returned word belongs to a dead stream
  } fetch_state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^32 and keeps any misalignment as-is.
  function automatic logic [InstAddrBus-1:0] pc_inc(input logic [InstAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: 2-entry {pc,inst} FIFO; slot 0 is always the head.
// Latency: a push is visible at the head in the cycle after the write edge.
// Backpressure: none internally; the caller never pushes into a full buffer.
// Ports: clk/rst (sync, active-high); push_i with push_pc_i/push_inst_i; pop_i drops the head;
//        clear_i empties the buffer (wins over push/pop); head_pc_o/head_inst_o raw head; count_o 0..2.
module if_fetch_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic [31:0] push_inst_i,
  input  logic        pop_i,
  input  logic        clear_i,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_inst_o,
  output logic [1:0]  count_o
);

  fetch_entry_t [1:0] ent_q, ent_d;
  logic [1:0]         count_q, count_d;
  logic               wr_idx;

  // Write slot after the optional pop has shifted slot 1 down.
  assign wr_idx = pop_i ? (count_q == 2'd2) : (count_q != 2'd0);

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_i) begin
        ent_d[0] = ent_q[1];
      end
      if (push_i) begin
        ent_d[wr_idx].pc   = push_pc_i;
        ent_d[wr_idx].inst = push_inst_i;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      ent_q   <= '0;
      count_q <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign head_pc_o   = ent_q[0].pc;
  assign head_inst_o = ent_q[0].inst;
  assign count_o     = count_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: MIPS IF stage; owns the PC, fetches over a req/ack port and buffers up to two words for IF/ID.
// Latency: ack at edge N gives if_valid_o in cycle N+1; zero-wait memory sustains one word per cycle.
// Backpressure: stall_i holds the head; with two words buffered and stall held no new request is issued.
// Ports: clk/rst (sync, active-high); stall_i, flush_i, new_pc_i from ctrl; branch_flag_i, branch_target_i
//        from ID; imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i instruction memory port;
//        if_pc_o/if_inst_o/if_valid_o head word to IF/ID; stallreq_o asks ctrl to stall while empty.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        stallreq_o
);

  fetch_state_e            state_q, state_d;
  logic [InstAddrBus-1:0]  pc_q, pc_d;
  logic [InstAddrBus-1:0]  addr_q, addr_d;
  logic                    req_q, req_d;

  logic [1:0]              buf_count;
  logic [InstAddrBus-1:0]  buf_pc;
  logic [InstBus-1:0]      buf_inst;

  logic                    consume, branch_take, redirect;
  logic                    ack_acc, push, outstanding_nxt, start;
  logic [1:0]              count_nxt;
  logic [InstAddrBus-1:0]  pc_redir;

  // A stalled branch is ignored: ID re-presents it once the stall lifts.
  assign consume     = !stall_i && (buf_count != 2'd0) && !flush_i;
  assign branch_take = branch_flag_i && !stall_i && !flush_i;
  assign redirect    = flush_i || branch_take;

  // req_q is low in the cycle after reset, so an ack there (or during reset) is ignored.
  assign ack_acc = imem_ack_i && req_q;
  assign push    = ack_acc && (state_q == BUSY) && !redirect;

  // On a branch the delay slot leaves as a normal pop and the second entry is discarded,
  // so both redirect kinds leave the buffer empty.
  assign count_nxt = redirect ? 2'd0 : (buf_count + {1'b0, push} - {1'b0, consume});
  assign pc_redir  = flush_i ? new_pc_i : (branch_take ? branch_target_i : pc_q);

  // Start only once the port is free and the buffer will have room for the reply,
  // which keeps buffered + outstanding at most two.
  assign outstanding_nxt = (state_q != IDLE) && !ack_acc;
  assign start           = !outstanding_nxt && (count_nxt <= 2'd1);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = BUSY;
    end else if (!outstanding_nxt) begin
      state_d = IDLE;
    end else if (redirect) begin
      // The pending reply now belongs to the old stream.
      state_d = DRAIN;
    end
  end

  always_comb begin
    req_d  = (state_d != IDLE);
    addr_d = start ? pc_redir : addr_q;
    pc_d   = start ? pc_inc(pc_redir) : pc_redir;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      req_q  <= 1'b0;
      addr_q <= ZeroWord;
      pc_q   <= RESET_PC;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      pc_q   <= pc_d;
    end
  end

  if_fetch_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_pc_i   (addr_q),
    .push_inst_i (imem_rdata_i),
    .pop_i       (consume),
    .clear_i     (redirect),
    .head_pc_o   (buf_pc),
    .head_inst_o (buf_inst),
    .count_o     (buf_count)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = (buf_count != 2'd0);
  assign stallreq_o  = (buf_count == 2'd0);
  assign if_pc_o     = if_valid_o ? buf_pc : ZeroWord;
  assign if_inst_o   = if_valid_o ? buf_inst : ZeroWord;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch with a behavioural memory and a stream-level model.
// Latency: n/a.
// Backpressure: the bench plays ctrl, stalling whenever stallreq_o is high plus random extra stalls.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, branch_flag_i, imem_ack_i;
  logic [31:0] new_pc_i, branch_target_i, imem_rdata_i;
  logic        imem_req_o, if_valid_o, stallreq_o;
  logic [31:0] imem_addr_o, if_pc_o, if_inst_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  // memory behaviour knobs
  int ack_delay = 0;
  bit ack_rand  = 1'b0;
  bit ack_force = 1'b0;
  int wait_cnt  = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_valid_o(if_valid_o), .stallreq_o(stallreq_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
  endfunction

  // Memory: decides the ack for the coming edge just after each edge.
  initial begin
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_force) begin
        imem_ack_i = 1'b1; imem_rdata_i = $urandom; wait_cnt = 0;
      end else if (imem_req_o) begin
        if (ack_rand ? ($urandom_range(0, 1) == 1) : (wait_cnt >= ack_delay)) begin
          imem_ack_i = 1'b1; imem_rdata_i = mem_word(imem_addr_o); wait_cnt = 0;
        end else begin
          imem_ack_i = 1'b0; imem_rdata_i = $urandom; wait_cnt++;
        end
      end else begin
        imem_ack_i = 1'b0; imem_rdata_i = $urandom; wait_cnt = 0;
      end
    end
  end

  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic fl, input logic [31:0] npc);
    stall_i = st; branch_flag_i = br; branch_target_i = tgt; flush_i = fl; new_pc_i = npc;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(stallreq_o, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0; new_pc_i = 32'h0; branch_target_i = 32'h0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ack_delay = 0; ack_force = 1'b1;
    rst = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0; new_pc_i = 32'h0; branch_target_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req_o, imem_addr_o, if_valid_o, stallreq_o} !== {1'b0, 32'h0, 1'b0, 1'b1})
      begin errors++; $display("FAIL reset_ctl: got req=%b addr=%h vld=%b sreq=%b required 0 0 0 1",
                               imem_req_o, imem_addr_o, if_valid_o, stallreq_o); end
    checks++;
    if ({if_pc_o, if_inst_o} !== 64'h0)
      begin errors++; $display("FAIL reset_head: got pc=%h inst=%h required 0 0", if_pc_o, if_inst_o); end
    // forced ack stays on into the first post-reset cycle
    rst = 1'b0; ack_force = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req_o, imem_addr_o, if_valid_o} !== {1'b1, 32'h0, 1'b0})
      begin errors++; $display("FAIL reset_first_req: got req=%b addr=%h vld=%b required 1 00000000 0",
                               imem_req_o, imem_addr_o, if_valid_o); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] ea, ep;
    for (int i = 1; i <= 8; i++) begin
      ea = 32'(4 * (i - 1));
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== ea)
        begin errors++; $display("FAIL zw_req c%0d: got req=%b addr=%h required 1 %h", i, imem_req_o, imem_addr_o, ea); end
      if (i >= 2) begin
        ep = 32'(4 * (i - 2));
        checks++;
        if (if_valid_o !== 1'b1 || stallreq_o !== 1'b0 || if_pc_o !== ep || if_inst_o !== mem_word(ep))
          begin errors++; $display("FAIL zw_head c%0d: got vld=%b pc=%h inst=%h required 1 %h %h",
                                   i, if_valid_o, if_pc_o, if_inst_o, ep, mem_word(ep)); end
      end else begin
        checks++;
        if (if_valid_o !== 1'b0 || stallreq_o !== 1'b1)
          begin errors++; $display("FAIL zw_empty: got vld=%b sreq=%b required 0 1", if_valid_o, stallreq_o); end
      end
      idle_step();
    end
    exp_pc = 32'h1C;
  endtask

  task automatic test_stall_full();
    logic [31:0] h;
    h = if_pc_o;
    checks++;
    if (h !== exp_pc) begin errors++; $display("FAIL sf_start: got %h required %h", h, exp_pc); end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== h || imem_req_o !== 1'b0)
        begin errors++; $display("FAIL sf_hold k%0d: got vld=%b pc=%h req=%b required 1 %h 0",
                                 k, if_valid_o, if_pc_o, imem_req_o, h); end
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc || if_inst_o !== mem_word(exp_pc))
        begin errors++; $display("FAIL sf_order j%0d: got vld=%b pc=%h inst=%h required 1 %h %h",
                                 j, if_valid_o, if_pc_o, if_inst_o, exp_pc, mem_word(exp_pc)); end
      if (j == 1) begin
        checks++;
        if (imem_req_o !== 1'b1) begin errors++; $display("FAIL sf_resume: got req=%b required 1", imem_req_o); end
      end
      exp_pc = exp_pc + 32'd4;
      idle_step();
    end
  endtask

  task automatic test_branch();
    do_reset(2);
    repeat (4) idle_step();
    checks++;
    if (if_pc_o !== 32'h8) begin errors++; $display("FAIL br_slot: got %h required 00000008", if_pc_o); end
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);   // buffer 0xC behind the delay slot
    checks++;
    if (if_pc_o !== 32'h8 || imem_req_o !== 1'b0)
      begin errors++; $display("FAIL br_full: got pc=%h req=%b required 00000008 0", if_pc_o, imem_req_o); end
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || if_valid_o !== 1'b0 || stallreq_o !== 1'b1)
      begin errors++; $display("FAIL br_req: got req=%b addr=%h vld=%b sreq=%b required 1 00000100 0 1",
                               imem_req_o, imem_addr_o, if_valid_o, stallreq_o); end
    idle_step();
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_inst_o !== mem_word(32'h100))
      begin errors++; $display("FAIL br_target: got vld=%b pc=%h required 1 00000100", if_valid_o, if_pc_o); end
  endtask

  task automatic test_flush_drain();
    do_reset(2);
    ack_delay = 0;
    repeat (4) idle_step();
    ack_delay = 3;
    idle_step();
    checks++;
    if (if_pc_o !== 32'hC || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10)
      begin errors++; $display("FAIL fd_setup: got pc=%h req=%b addr=%h required 0000000c 1 00000010",
                               if_pc_o, imem_req_o, imem_addr_o); end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h180);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || if_valid_o !== 1'b0 || stallreq_o !== 1'b1)
        begin errors++; $display("FAIL fd_drain k%0d: got req=%b addr=%h vld=%b sreq=%b required 1 00000010 0 1",
                                 k, imem_req_o, imem_addr_o, if_valid_o, stallreq_o); end
      idle_step();
    end
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h180 || if_valid_o !== 1'b0)
      begin errors++; $display("FAIL fd_newreq: got req=%b addr=%h vld=%b required 1 00000180 0",
                               imem_req_o, imem_addr_o, if_valid_o); end
    ack_delay = 0;
    for (int k = 0; k < 10 && !if_valid_o; k++) idle_step();
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h180 || if_inst_o !== mem_word(32'h180))
      begin errors++; $display("FAIL fd_first: got vld=%b pc=%h required 1 00000180", if_valid_o, if_pc_o); end
  endtask

  task automatic test_flush_branch();
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h180);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h180 || if_valid_o !== 1'b0)
      begin errors++; $display("FAIL fb_req: got req=%b addr=%h vld=%b required 1 00000180 0",
                               imem_req_o, imem_addr_o, if_valid_o); end
    for (int k = 0; k < 10 && !if_valid_o; k++) idle_step();
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h180)
      begin errors++; $display("FAIL fb_resume: got vld=%b pc=%h required 1 00000180", if_valid_o, if_pc_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    e = 32'hFFFF_FFF8;
    step(1'b0, 1'b0, 32'h0, 1'b1, e);
    for (int k = 0; k < 10 && !if_valid_o; k++) idle_step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== e || if_inst_o !== mem_word(e))
        begin errors++; $display("FAIL wrap k%0d: got vld=%b pc=%h required 1 %h", k, if_valid_o, if_pc_o, e); end
      e = e + 32'd4;
      idle_step();
    end
  endtask

  task automatic test_reset_mid();
    ack_delay = 5;
    repeat (2) idle_step();
    checks++;
    if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rm_pending: got req=%b required 1", imem_req_o); end
    rst = 1'b1; ack_force = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req_o, imem_addr_o, if_valid_o, stallreq_o} !== {1'b0, 32'h0, 1'b0, 1'b1})
      begin errors++; $display("FAIL rm_reset: got req=%b addr=%h vld=%b sreq=%b required 0 0 0 1",
                               imem_req_o, imem_addr_o, if_valid_o, stallreq_o); end
    rst = 1'b0; ack_force = 1'b0; ack_delay = 0;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0)
      begin errors++; $display("FAIL rm_first: got req=%b addr=%h vld=%b required 1 00000000 0",
                               imem_req_o, imem_addr_o, if_valid_o); end
    idle_step();
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== mem_word(32'h0))
      begin errors++; $display("FAIL rm_word: got vld=%b pc=%h inst=%h required 1 00000000 %h",
                               if_valid_o, if_pc_o, if_inst_o, mem_word(32'h0)); end
    exp_pc = 32'h0;
  endtask

  task automatic test_random();
    logic        extra, br, fl, st, prev_req, prev_ack;
    logic [31:0] tgt, npc, prev_addr;
    int          starve;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0; starve = 0;
    ack_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (stallreq_o !== !if_valid_o || (!if_valid_o && (if_pc_o !== 32'h0 || if_inst_o !== 32'h0)))
        begin errors++; $display("FAIL rnd_outs n%0d: got vld=%b sreq=%b pc=%h inst=%h",
                                 n, if_valid_o, stallreq_o, if_pc_o, if_inst_o); end
      if (prev_req && !prev_ack) begin
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr)
          begin errors++; $display("FAIL rnd_addr_stable n%0d: got req=%b addr=%h required 1 %h",
                                   n, imem_req_o, imem_addr_o, prev_addr); end
      end
      extra = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 29) == 0);
      br    = ($urandom_range(0, 9) == 0);
      st    = !if_valid_o || extra;
      tgt   = $urandom & 32'h0000_0FFC;
      npc   = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'b10;
      if (if_valid_o && !st && !fl) begin
        checks++;
        if (if_pc_o !== exp_pc || if_inst_o !== mem_word(exp_pc))
          begin errors++; $display("FAIL rnd_stream n%0d: got pc=%h inst=%h required %h %h",
                                   n, if_pc_o, if_inst_o, exp_pc, mem_word(exp_pc)); end
        exp_pc = br ? tgt : exp_pc + 32'd4;
      end
      if (fl) exp_pc = npc;
      starve = if_valid_o ? 0 : starve + 1;
      if (starve > 40) begin
        errors++; $display("FAIL rnd_starve n%0d: got no word for %0d cycles required <= 40", n, starve);
        break;
      end
      prev_req = imem_req_o; prev_ack = imem_ack_i; prev_addr = imem_addr_o;
      step(st, br, tgt, fl, npc);
    end
    ack_rand = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_full();
    test_branch();
    test_flush_drain();
    test_flush_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
